// File: rtl/victim_cache_nway.sv
// Fully-associative N-line victim cache between L1 and L2 with true-LRU ages.
// Define VC_STATS_EN to add saturating hit_count / miss_count outputs.
module victim_cache_nway #(
    parameter int NUM_ENTRIES = 4,
    parameter int LINE_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l1_read,
    input  logic                  l1_write,
    input  logic [ADDR_WIDTH-1:0] l1_address,
    input  logic [LINE_WIDTH-1:0] l1_wdata,
    input  logic                  l1_wdirty,
    output logic [LINE_WIDTH-1:0] l1_rdata,
    output logic                  l1_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
`ifdef VC_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int IW = $clog2(NUM_ENTRIES);
    localparam logic [IW-1:0] LRU_AGE = IW'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_HIT,
        RD_L2,
        WB_L2,
        INSERT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_WIDTH-1:0]  r_tag  [NUM_ENTRIES];
    logic [LINE_WIDTH-1:0]  r_data [NUM_ENTRIES];
    logic [IW-1:0]          r_age  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [NUM_ENTRIES-1:0] r_dirty;

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [LINE_WIDTH-1:0]  r_wdata;
    logic                   r_wdirty;
    logic [IW-1:0]          r_idx;
    logic                   r_merge;

    logic [NUM_ENTRIES-1:0] w_hit_vec;
    logic                   w_hit;
    logic                   w_free;
    logic [IW-1:0]          w_hit_idx;
    logic [IW-1:0]          w_free_idx;
    logic [IW-1:0]          w_lru_idx;
    logic [IW-1:0]          w_sel_idx;
    logic                   w_sel_merge;
    logic                   w_accept;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin : lookup
        w_hit_vec  = '0;
        w_hit_idx  = '0;
        w_free_idx = '0;
        w_lru_idx  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            w_hit_vec[i] = r_valid[i] && (r_tag[i] == l1_address);
            if (w_hit_vec[i]) begin
                w_hit_idx = IW'(i);
            end
            if (!r_valid[i]) begin
                w_free_idx = IW'(i);
            end
            if (r_age[i] == LRU_AGE) begin
                w_lru_idx = IW'(i);
            end
        end
        w_hit  = |w_hit_vec;
        w_free = ~&r_valid;
    end

    always_comb begin : fsm_next
        w_next      = r_state;
        w_sel_idx   = r_idx;
        w_sel_merge = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (l1_write) begin
                    w_accept = 1'b1;
                    if (w_hit) begin
                        w_next      = INSERT;
                        w_sel_idx   = w_hit_idx;
                        w_sel_merge = 1'b1;
                    end else if (w_free) begin
                        w_next    = INSERT;
                        w_sel_idx = w_free_idx;
                    end else if (!r_dirty[w_lru_idx]) begin
                        w_next    = INSERT;
                        w_sel_idx = w_lru_idx;
                    end else begin
                        w_next    = WB_L2;
                        w_sel_idx = w_lru_idx;
                    end
                end else if (l1_read) begin
                    w_accept = 1'b1;
                    if (w_hit) begin
                        w_next    = RD_HIT;
                        w_sel_idx = w_hit_idx;
                    end else begin
                        w_next = RD_L2;
                    end
                end
            end
            RD_HIT: w_next = IDLE;
            RD_L2: begin
                if (l2_resp) begin
                    w_next = IDLE;
                end
            end
            WB_L2: begin
                if (l2_resp) begin
                    w_next = INSERT;
                end
            end
            INSERT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : ctrl
        if (rst) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            r_idx   <= '0;
            r_merge <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_age[i] <= IW'(i);
            end
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx   <= w_sel_idx;
                r_merge <= w_sel_merge;
            end
            case (r_state)
                RD_HIT: begin
                    r_valid[r_idx] <= 1'b0;
                    r_dirty[r_idx] <= 1'b0;
                end
                WB_L2: begin
                    if (l2_resp) begin
                        r_dirty[r_idx] <= 1'b0;
                    end
                end
                INSERT: begin
                    r_valid[r_idx] <= 1'b1;
                    r_dirty[r_idx] <= (r_merge & r_dirty[r_idx]) | r_wdirty;
                    for (int j = 0; j < NUM_ENTRIES; j++) begin
                        if (IW'(j) == r_idx) begin
                            r_age[j] <= '0;
                        end else if (r_age[j] < r_age[r_idx]) begin
                            r_age[j] <= r_age[j] + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage and captured request need no reset.
    always_ff @(posedge clk) begin : datapath
        if (w_accept) begin
            r_addr   <= l1_address;
            r_wdata  <= l1_wdata;
            r_wdirty <= l1_wdirty;
        end
        if (r_state == INSERT && !rst) begin
            r_tag[r_idx]  <= r_addr;
            r_data[r_idx] <= r_wdata;
        end
    end

    always_comb begin : fsm_out
        l1_resp    = 1'b0;
        l1_rdata   = '0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
        case (r_state)
            RD_HIT: begin
                l1_resp  = !rst;
                l1_rdata = r_data[r_idx];
            end
            RD_L2: begin
                l2_read    = 1'b1;
                l2_address = r_addr;
                if (l2_resp) begin
                    l1_resp  = !rst;
                    l1_rdata = l2_rdata;
                end
            end
            WB_L2: begin
                l2_write   = 1'b1;
                l2_address = r_tag[r_idx];
                l2_wdata   = r_data[r_idx];
            end
            INSERT: l1_resp = !rst;
            default: ;
        endcase
    end

`ifdef VC_STATS_EN
    always_ff @(posedge clk) begin : stats
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == IDLE && l1_read && !l1_write) begin
            if (w_hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else begin
                if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_victim_cache_nway.sv
// Directed bench for victim_cache_nway (N=4) with a latency-programmable L2.
module tb_victim_cache_nway;

    localparam int N  = 4;
    localparam int LW = 256;
    localparam int AW = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          l1_read;
    logic          l1_write;
    logic [AW-1:0] l1_address;
    logic [LW-1:0] l1_wdata;
    logic          l1_wdirty;
    logic [LW-1:0] l1_rdata;
    logic          l1_resp;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_address;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] l2_rdata;
    logic          l2_resp;
`ifdef VC_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    victim_cache_nway #(
        .NUM_ENTRIES(N),
        .LINE_WIDTH (LW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .l1_read   (l1_read),
        .l1_write  (l1_write),
        .l1_address(l1_address),
        .l1_wdata  (l1_wdata),
        .l1_wdirty (l1_wdirty),
        .l1_rdata  (l1_rdata),
        .l1_resp   (l1_resp),
        .l2_read   (l2_read),
        .l2_write  (l2_write),
        .l2_address(l2_address),
        .l2_wdata  (l2_wdata),
        .l2_rdata  (l2_rdata),
        .l2_resp   (l2_resp)
`ifdef VC_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int l2_lat    = 3;
    bit l2_fixed  = 1'b0;
    int n_rd      = 0;
    int n_wr      = 0;
    int both_cnt  = 0;
    int resp_seen = 0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [LW-1:0] last_wr_data = '0;

    function automatic logic [LW-1:0] vline(input logic [AW-1:0] a);
        return {8{32'hC0DE_0000 ^ 32'(a)}};
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // L2 model: answers after l2_lat cycles of a held request
    initial begin : l2_model
        int cnt;
        cnt      = 0;
        l2_resp  = 1'b0;
        l2_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            l2_resp = 1'b0;
            if (l2_read || l2_write) begin
                if (cnt >= l2_lat - 1) begin
                    l2_resp  = 1'b1;
                    l2_rdata = l2_fixed ? {32{8'hAA}} : ~vline(l2_address);
                    if (l2_read) begin
                        n_rd++;
                        last_rd_addr = l2_address;
                    end else begin
                        n_wr++;
                        last_wr_addr = l2_address;
                        last_wr_data = l2_wdata;
                    end
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (l2_read && l2_write) both_cnt++;
        if (l1_resp) resp_seen++;
    end

    task automatic wait_resp(output int cyc, output logic [LW-1:0] rd);
        bit done;
        done = 1'b0;
        cyc  = 0;
        rd   = '0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (l1_resp) begin
                done = 1'b1;
                rd   = l1_rdata;
            end
        end
        if (!done) chk("resp_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit wr, input logic [AW-1:0] a,
                       input logic [LW-1:0] d, input bit dty,
                       output int cyc, output logic [LW-1:0] rd);
        l1_write   = wr;
        l1_read    = !wr;
        l1_address = a;
        l1_wdata   = d;
        l1_wdirty  = dty;
        wait_resp(cyc, rd);
        l1_write = 1'b0;
        l1_read  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : main
        int cyc;
        int base_rd;
        int base_wr;
        int base_resp;
        bit seen;
        logic [LW-1:0] rd;
        l1_read    = 1'b0;
        l1_write   = 1'b0;
        l1_address = '0;
        l1_wdata   = '0;
        l1_wdirty  = 1'b0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_l1_resp", l1_resp, 0);
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Read miss to empty array, L2 returns AA..AA
        l2_fixed = 1'b1;
        req(1'b0, 27'h100, '0, 1'b0, cyc, rd);
        chk("t1_cyc", cyc, 4);
        chk("t1_data", rd, {32{8'hAA}});
        chk("t1_nrd", n_rd, 1);
        chk("t1_addr", last_rd_addr, 27'h100);
        l2_fixed = 1'b0;
        req(1'b0, 27'h100, '0, 1'b0, cyc, rd);
        chk("t1_again_cyc", cyc, 4);
        chk("t1_again_data", rd, ~vline(27'h100));
`ifdef VC_STATS_EN
        chk("t1_miss_cnt", miss_count, 2);
        chk("t1_hit_cnt", hit_count, 0);
`endif

        // Clean evictions then an exclusive read hit
        do_reset();
        base_rd = n_rd;
        base_wr = n_wr;
        for (int i = 0; i < 4; i++) begin
            req(1'b1, AW'(27'h10 + i), vline(AW'(27'h10 + i)), 1'b0, cyc, rd);
            chk("t2_ev_cyc", cyc, 2);
        end
        chk("t2_no_wr", n_wr - base_wr, 0);
        req(1'b0, 27'h12, '0, 1'b0, cyc, rd);
        chk("t2_hit_cyc", cyc, 2);
        chk("t2_hit_data", rd, vline(27'h12));
        chk("t2_hit_nrd", n_rd - base_rd, 0);
        req(1'b0, 27'h12, '0, 1'b0, cyc, rd);
        chk("t2_reread_cyc", cyc, 4);
        chk("t2_reread_data", rd, ~vline(27'h12));
        chk("t2_reread_nrd", n_rd - base_rd, 1);

        // Dirty fill, touch 0x20, evict 0x30 forces write-back of 0x21
        do_reset();
        l2_lat = 2;
        for (int i = 0; i < 4; i++) begin
            req(1'b1, AW'(27'h20 + i), vline(AW'(27'h20 + i)), 1'b1, cyc, rd);
        end
        req(1'b1, 27'h20, vline(27'h120), 1'b0, cyc, rd);
        chk("t3_touch_cyc", cyc, 2);
        base_wr = n_wr;
        base_rd = n_rd;
        req(1'b1, 27'h30, vline(27'h30), 1'b0, cyc, rd);
        chk("t3_wb_cyc", cyc, 4);
        chk("t3_wb_n", n_wr - base_wr, 1);
        chk("t3_wb_addr", last_wr_addr, 27'h21);
        chk("t3_wb_data", last_wr_data, vline(27'h21));
        req(1'b0, 27'h30, '0, 1'b0, cyc, rd);
        chk("t3_rd30_cyc", cyc, 2);
        chk("t3_rd30_data", rd, vline(27'h30));
        req(1'b0, 27'h20, '0, 1'b0, cyc, rd);
        chk("t3_rd20_cyc", cyc, 2);
        chk("t3_rd20_data", rd, vline(27'h120));
        chk("t3_nrd", n_rd - base_rd, 0);

        // Full with clean LRU: drop without write-back
        do_reset();
        l2_lat = 3;
        for (int i = 0; i < 4; i++) begin
            req(1'b1, AW'(27'h40 + i), vline(AW'(27'h40 + i)), 1'b0, cyc, rd);
        end
        base_wr = n_wr;
        base_rd = n_rd;
        req(1'b1, 27'h50, vline(27'h50), 1'b0, cyc, rd);
        chk("t4_ev_cyc", cyc, 2);
        chk("t4_no_wr", n_wr - base_wr, 0);
        req(1'b0, 27'h40, '0, 1'b0, cyc, rd);
        chk("t4_rd40_cyc", cyc, 4);
        chk("t4_rd40_data", rd, ~vline(27'h40));
        chk("t4_rd40_nrd", n_rd - base_rd, 1);
        req(1'b0, 27'h50, '0, 1'b0, cyc, rd);
        chk("t4_rd50_data", rd, vline(27'h50));

        // Simultaneous read and write: write first
        do_reset();
        base_rd = n_rd;
        l1_write   = 1'b1;
        l1_read    = 1'b1;
        l1_address = 27'h60;
        l1_wdata   = vline(27'h60);
        l1_wdirty  = 1'b0;
        wait_resp(cyc, rd);
        chk("t5_wr_cyc", cyc, 2);
        l1_write = 1'b0;
        wait_resp(cyc, rd);
        l1_read = 1'b0;
        chk("t5_rd_cyc", cyc, 2);
        chk("t5_rd_data", rd, vline(27'h60));
        chk("t5_nrd", n_rd - base_rd, 0);

        // Reset while waiting in write-back
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req(1'b1, AW'(27'h70 + i), vline(AW'(27'h70 + i)), 1'b1, cyc, rd);
        end
        l2_lat     = 20;
        l1_write   = 1'b1;
        l1_address = 27'h80;
        l1_wdata   = vline(27'h80);
        l1_wdirty  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = l2_write;
        end
        chk("t6_wb_seen", seen, 1);
        @(posedge clk);
        #1;
        base_resp = resp_seen;
        rst      = 1'b1;
        l1_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_wr_drop", l2_write, 0);
        chk("t6_no_resp", resp_seen - base_resp, 0);
`ifdef VC_STATS_EN
        chk("t6_hit_cnt", hit_count, 0);
        chk("t6_miss_cnt", miss_count, 0);
`endif
        @(posedge clk);
        #1;
        rst    = 1'b0;
        l2_lat = 3;
        base_rd = n_rd;
        req(1'b0, 27'h70, '0, 1'b0, cyc, rd);
        chk("t6_rd70_cyc", cyc, 4);
        chk("t6_rd70_data", rd, ~vline(27'h70));
        req(1'b0, 27'h73, '0, 1'b0, cyc, rd);
        chk("t6_rd73_cyc", cyc, 4);
        chk("t6_nrd", n_rd - base_rd, 2);

        chk("l2_exclusive", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/victim_cache_nway.md
Name: victim_cache_nway

Overview:
- Parametrised, fully-associative victim cache with its own tag, data, valid and dirty storage and its own control FSM.
- Sits between the L1 cache (upstream) and L2 (downstream).
- Receives L1 evictions and services L1 miss reads from the victim array, falling back to L2.
- Generalises the fixed 4-line victim controller to NUM_ENTRIES lines, true-LRU ages, in-place overwrite and per-line dirty write-back.

Parameters:
- NUM_ENTRIES, 4, number of victim lines; power of two, 2..16.
- LINE_WIDTH, 256, bits per cache line.
- ADDR_WIDTH, 27, line-address width (byte offset stripped).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- l1_read  in  1  L1 miss read request; held until l1_resp.
- l1_write  in  1  L1 eviction request; held until l1_resp.
- l1_address  in  ADDR_WIDTH  line address of the request.
- l1_wdata  in  LINE_WIDTH  evicted line data.
- l1_wdirty  in  1  evicted line is dirty.
- l1_rdata  out  LINE_WIDTH  read data; valid while l1_resp=1.
- l1_resp  out  1  one-cycle completion pulse.
- l2_read  out  1  L2 read request; held until l2_resp.
- l2_write  out  1  L2 write-back request; held until l2_resp.
- l2_address  out  ADDR_WIDTH  L2 line address.
- l2_wdata  out  LINE_WIDTH  write-back data.
- l2_rdata  in  LINE_WIDTH  L2 read data; valid with l2_resp.
- l2_resp  in  1  L2 completion pulse.

Behaviour:
- Reset: state=IDLE; all valid and dirty bits cleared; age[i]=i; all outputs 0. Data and tag contents are don't-care.
- Reset mid-operation aborts the transaction. l2_read/l2_write drop the next cycle, no l1_resp is issued, and an in-flight line is lost.
- Lookup is combinational in IDLE: hit = valid & tag==l1_address, over all entries.
- At most one entry may match. If more than one matches, the lowest index wins.
- IDLE priority: l1_write over l1_read. The request is captured into internal registers when it is accepted.
- FSM states: IDLE, RD_HIT, RD_L2, WB_L2, INSERT.
- IDLE, l1_write:
  - hit: go to INSERT, overwrite in place; new dirty = old dirty | l1_wdirty.
  - no hit, some entry invalid: go to INSERT into the lowest-index invalid entry.
  - full, LRU clean: go to INSERT over the LRU entry; the LRU line is dropped.
  - full, LRU dirty: go to WB_L2.
- IDLE, l1_read:
  - hit: go to RD_HIT.
  - miss: go to RD_L2.
- INSERT (1 cycle):
  - write tag, data and dirty; valid=1; touch the entry.
  - l1_resp=1; go to IDLE.
  - Eviction latency: 2 cycles from request to l1_resp when no write-back is needed.
- WB_L2:
  - l2_write=1, l2_address=LRU tag, l2_wdata=LRU data.
  - on l2_resp: clear that dirty bit; go to INSERT.
- RD_HIT (1 cycle):
  - l1_rdata=entry data; l1_resp=1.
  - invalidate the entry (exclusive with L1; the line moves up); go to IDLE.
  - if the entry was dirty, the L1 copy is still dirty; victim-side dirty state is discarded.
- RD_L2:
  - l2_read=1, l2_address=captured address.
  - on l2_resp: l1_rdata=l2_rdata, l1_resp=1 in the same cycle; go to IDLE.
  - nothing is installed in the victim array.
- LRU ages: clog2(NUM_ENTRIES)-bit counters, always a permutation of 0..N-1.
  - touch(e): every entry whose age < age[e] increments; age[e]=0.
  - LRU = the entry with age N-1.
- Handshake: L1 deasserts the request, or presents a new one, in the cycle after l1_resp. The FSM samples requests only in IDLE.
- l2_read and l2_write are never both 1.
- All outputs are 0 whenever their qualifying state is inactive, except l1_rdata, which is don't-care.

Optional Feature:
- VC_STATS_EN defined:
  - adds outputs hit_count[31:0] and miss_count[31:0], both saturating at 32'hFFFFFFFF and cleared by rst.
  - hit_count increments once per read accepted as a hit.
  - miss_count increments once per read accepted as a miss.
- VC_STATS_EN undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Reset, then read 0x100, L2 returns 0xAA..AA after 3 cycles -> l2_read held with addr 0x100; l1_resp and l1_rdata=0xAA..AA in the l2_resp cycle; array still empty.
- Evict clean lines 0x10..0x13 (N=4), then read 0x12 -> each eviction: l1_resp on cycle 2, no L2 traffic; read: l1_resp on cycle 2 with 0x12 data, no l2_read; a second read of 0x12 goes to L2.
- Fill 0x20..0x23 dirty, touch 0x20 by a re-evict, evict 0x30 -> l2_write addr 0x21 with its data; after l2_resp, 0x30 inserted; 0x20 still resident.
- Full array with clean LRU 0x40, evict 0x50 -> no l2_write; 0x40 dropped; a read of 0x40 goes to L2.
- l1_read and l1_write both asserted in IDLE -> write serviced first, read serviced after the next IDLE.
- Assert rst during WB_L2 -> l2_write low the next cycle, no l1_resp, all lines invalid; with VC_STATS_EN, counters are 0.
